// File: rtl/argmax_classifier.sv
// Sequential arg-max over NUM_INPUTS signed fixed-point class scores, one compare per cycle.
// Define ARGMAX_MARGIN_EN to add runner_up and margin (best minus second best, saturated).
module argmax_classifier #(
    parameter int NUM_INPUTS     = 10,
    parameter int INTEGER_WIDTH  = 8,
    parameter int FRACTION_WIDTH = 8,
    localparam int INDEX_WIDTH   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        inputs_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    output logic        [INDEX_WIDTH-1:0]               prediction,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] max_value,
    output logic                                        outputs_ready
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic        [INDEX_WIDTH-1:0]               runner_up,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] margin
`endif
);

    localparam int W = INTEGER_WIDTH + FRACTION_WIDTH;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] score_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam index_t LAST_IDX  = index_t'(NUM_INPUTS - 1);
    localparam score_t MOST_NEG  = score_t'({1'b1, {(W-1){1'b0}}});
    localparam score_t MOST_POS  = score_t'({1'b0, {(W-1){1'b1}}});

    state_t state_q, state_d;
    index_t counter_q, counter_d;
    score_t bank_q [NUM_INPUTS];
    score_t bank_d [NUM_INPUTS];
    score_t best_q, best_d;
    index_t best_idx_q, best_idx_d;
    index_t prediction_q, prediction_d;
    score_t max_value_q, max_value_d;
    logic   outputs_ready_q, outputs_ready_d;
    logic   prev_ready_q, prev_ready_d;
    logic   start;
    score_t candidate;
    logic   greater;
`ifdef ARGMAX_MARGIN_EN
    score_t second_q, second_d;
    index_t second_idx_q, second_idx_d;
    index_t runner_up_q, runner_up_d;
    score_t margin_q, margin_d;
    logic signed [W:0] diff;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            counter_q       <= '0;
            best_q          <= '0;
            best_idx_q      <= '0;
            prediction_q    <= '0;
            max_value_q     <= '0;
            outputs_ready_q <= 1'b0;
            prev_ready_q    <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q        <= '0;
            second_idx_q    <= '0;
            runner_up_q     <= '0;
            margin_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            best_q          <= best_d;
            best_idx_q      <= best_idx_d;
            prediction_q    <= prediction_d;
            max_value_q     <= max_value_d;
            outputs_ready_q <= outputs_ready_d;
            prev_ready_q    <= prev_ready_d;
`ifdef ARGMAX_MARGIN_EN
            second_q        <= second_d;
            second_idx_q    <= second_idx_d;
            runner_up_q     <= runner_up_d;
            margin_q        <= margin_d;
`endif
        end
    end

    // The score bank only changes on a captured start, so it needs no reset.
    always_ff @(posedge clock) begin
        bank_q <= bank_d;
    end

    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        bank_d          = bank_q;
        best_d          = best_q;
        best_idx_d      = best_idx_q;
        prediction_d    = prediction_q;
        max_value_d     = max_value_q;
        outputs_ready_d = outputs_ready_q;
        prev_ready_d    = inputs_ready;
        start           = inputs_ready & ~prev_ready_q;
        candidate       = bank_q[counter_q];
        greater         = candidate > best_q;
`ifdef ARGMAX_MARGIN_EN
        second_d        = second_q;
        second_idx_d    = second_idx_q;
        runner_up_d     = runner_up_q;
        margin_d        = margin_q;
        diff            = '0;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bank_d          = inputs;
                    best_d          = inputs[0];
                    best_idx_d      = '0;
                    counter_d       = index_t'(1);
                    outputs_ready_d = 1'b0;
                    state_d         = SCAN;
`ifdef ARGMAX_MARGIN_EN
                    second_d        = MOST_NEG;
                    second_idx_d    = '0;
`endif
                    if (NUM_INPUTS == 1) begin
                        prediction_d    = '0;
                        max_value_d     = inputs[0];
                        outputs_ready_d = 1'b1;
                        state_d         = DONE;
`ifdef ARGMAX_MARGIN_EN
                        runner_up_d     = '0;
                        margin_d        = MOST_POS;
`endif
                    end
                end
            end
            SCAN: begin
                // Strictly greater only, so ties keep the lowest index.
                if (greater) begin
                    best_d     = candidate;
                    best_idx_d = counter_q;
`ifdef ARGMAX_MARGIN_EN
                    second_d     = best_q;
                    second_idx_d = best_idx_q;
                end else if (candidate > second_q) begin
                    second_d     = candidate;
                    second_idx_d = counter_q;
`endif
                end
                counter_d = counter_q + index_t'(1);
                if (counter_q == LAST_IDX) begin
                    prediction_d    = best_idx_d;
                    max_value_d     = best_d;
                    outputs_ready_d = 1'b1;
                    state_d         = DONE;
`ifdef ARGMAX_MARGIN_EN
                    diff        = {best_d[INTEGER_WIDTH-1], best_d} - {second_d[INTEGER_WIDTH-1], second_d};
                    runner_up_d = second_idx_d;
                    margin_d    = (diff[W] == 1'b0 && diff[W-1] == 1'b1) ? MOST_POS : score_t'(diff[W-1:0]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prediction    = prediction_q;
    assign max_value     = max_value_q;
    assign outputs_ready = outputs_ready_q;
`ifdef ARGMAX_MARGIN_EN
    assign runner_up     = runner_up_q;
    assign margin        = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier (NUM_INPUTS=10, Q8.8 scores); extra margin checks when ARGMAX_MARGIN_EN is defined.
module tb_argmax_classifier;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic inputs_ready = 1'b0;
    logic signed [7:-8] scores [10];
    logic [3:0] prediction;
    logic signed [7:-8] max_value;
    logic outputs_ready;
    int errors = 0;
    int checks = 0;
    int vec [10];
    int n;
    int pulses;
`ifdef ARGMAX_MARGIN_EN
    logic [3:0] runner_up;
    logic signed [7:-8] margin;
    logic inputs_ready3 = 1'b0;
    logic signed [7:-8] scores3 [3];
    logic [1:0] prediction3;
    logic signed [7:-8] max_value3;
    logic outputs_ready3;
    logic [1:0] runner_up3;
    logic signed [7:-8] margin3;
`endif

    always #5 clock = ~clock;

    argmax_classifier #(.NUM_INPUTS(10), .INTEGER_WIDTH(8), .FRACTION_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(scores),
        .prediction(prediction), .max_value(max_value), .outputs_ready(outputs_ready)
`ifdef ARGMAX_MARGIN_EN
        , .runner_up(runner_up), .margin(margin)
`endif
    );

`ifdef ARGMAX_MARGIN_EN
    argmax_classifier #(.NUM_INPUTS(3), .INTEGER_WIDTH(8), .FRACTION_WIDTH(8)) dut3 (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready3), .inputs(scores3),
        .prediction(prediction3), .max_value(max_value3), .outputs_ready(outputs_ready3),
        .runner_up(runner_up3), .margin(margin3)
    );
`endif

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int v [10]);
        for (int i = 0; i < 10; i++) scores[i] = 16'(v[i]);
        inputs_ready = 1'b1;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!outputs_ready && cycles < 50);
    endtask

    initial begin
        vec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) scores[i] = '0;
`ifdef ARGMAX_MARGIN_EN
        for (int i = 0; i < 3; i++) scores3[i] = '0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_prediction", int'(prediction), 0);
        checkOutput("reset_max_value", int'(max_value), 0);
        checkOutput("reset_outputs_ready", int'(outputs_ready), 0);

        // Basic vector; -1.0 would win an unsigned compare
        vec = '{128, -256, 832, 512, 0, 0, 0, 0, 0, 0};
        applyStimulus(vec);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("basic_not_ready_at_c0+9", int'(outputs_ready), 0);
        checkOutput("basic_prediction_held_in_scan", int'(prediction), 0);
        tick();
        checkOutput("basic_ready_at_c0+10", int'(outputs_ready), 1);
        checkOutput("basic_prediction", int'(prediction), 2);
        checkOutput("basic_max_value", int'(max_value), 832);
`ifdef ARGMAX_MARGIN_EN
        checkOutput("basic_runner_up", int'(runner_up), 3);
        checkOutput("basic_margin", int'(margin), 320);
`endif

        // All equal 1.0: lowest index wins
        inputs_ready = 1'b0;
        tick();
        vec = '{256, 256, 256, 256, 256, 256, 256, 256, 256, 256};
        applyStimulus(vec);
        waitResult(n);
        checkOutput("tie_latency", n, 10);
        checkOutput("tie_prediction", int'(prediction), 0);
        checkOutput("tie_max_value", int'(max_value), 256);
`ifdef ARGMAX_MARGIN_EN
        checkOutput("tie_margin", int'(margin), 0);
`endif

        // All negative, max -0.25 at the last index
        inputs_ready = 1'b0;
        tick();
        vec = '{-128, -192, -256, -320, -384, -448, -512, -576, -640, -64};
        applyStimulus(vec);
        waitResult(n);
        checkOutput("neg_latency", n, 10);
        checkOutput("neg_prediction", int'(prediction), 9);
        checkOutput("neg_max_value", int'(max_value), -64);

        // inputs_ready held high: no second classification
        vec = '{0, 0, 0, 0, 0, 768, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) scores[i] = 16'(vec[i]);
        for (int i = 0; i < 12; i++) tick();
        checkOutput("held_outputs_ready", int'(outputs_ready), 1);
        checkOutput("held_prediction", int'(prediction), 9);

        // Restart mid-scan is ignored and changed inputs are not seen
        inputs_ready = 1'b0;
        tick();
        applyStimulus(vec);
        tick();
        tick();
        tick();
        inputs_ready = 1'b0;
        vec = '{-128, -128, -128, -128, -128, -128, -128, 64, -128, -128};
        for (int i = 0; i < 10; i++) scores[i] = 16'(vec[i]);
        tick();
        inputs_ready = 1'b1;
        waitResult(n);
        checkOutput("midscan_remaining_latency", n, 6);
        checkOutput("midscan_prediction", int'(prediction), 5);
        checkOutput("midscan_max_value", int'(max_value), 768);
        tick();
        tick();
        checkOutput("midscan_no_requeue", int'(prediction), 5);

        // New start from DONE
        inputs_ready = 1'b0;
        tick();
        applyStimulus(vec);
        waitResult(n);
        checkOutput("done_restart_latency", n, 10);
        checkOutput("done_restart_prediction", int'(prediction), 7);
        checkOutput("done_restart_max_value", int'(max_value), 64);

        // Reset three cycles into a scan
        inputs_ready = 1'b0;
        tick();
        vec = '{0, 0, 0, 1000, 0, 0, 0, 0, 0, 0};
        applyStimulus(vec);
        tick();
        tick();
        tick();
        reset = 1'b1;
        inputs_ready = 1'b0;
        tick();
        checkOutput("abort_prediction", int'(prediction), 0);
        checkOutput("abort_max_value", int'(max_value), 0);
        checkOutput("abort_outputs_ready", int'(outputs_ready), 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (outputs_ready) pulses++;
        end
        checkOutput("abort_no_result_pulse", pulses, 0);

        // inputs_ready already high when reset releases counts as a start
        reset = 1'b1;
        vec = '{128, -256, 832, 512, 0, 0, 0, 0, 0, 0};
        applyStimulus(vec);
        tick();
        reset = 1'b0;
        waitResult(n);
        checkOutput("release_high_latency", n, 10);
        checkOutput("release_high_prediction", int'(prediction), 2);

`ifdef ARGMAX_MARGIN_EN
        // Three-input margin cases
        scores3[0] = 16'sd1024;
        scores3[1] = 16'sd256;
        scores3[2] = 16'sd896;
        inputs_ready3 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!outputs_ready3 && n < 50);
        checkOutput("m3_latency", n, 3);
        checkOutput("m3_prediction", int'(prediction3), 0);
        checkOutput("m3_runner_up", int'(runner_up3), 2);
        checkOutput("m3_margin", int'(margin3), 128);
        inputs_ready3 = 1'b0;
        tick();
        scores3[0] = 16'sh7FFF;
        scores3[1] = 16'sh8000;
        scores3[2] = 16'sh8000;
        inputs_ready3 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!outputs_ready3 && n < 50);
        checkOutput("m3_sat_max_value", int'(max_value3), 32767);
        checkOutput("m3_sat_margin", int'(margin3), 32767);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
